// File: rtl/psk8_symbol_mapper.sv
// 8-PSK symbol mapper: packs a serial bitstream into 3-bit symbols (MSB first), Gray-maps them
// and presents one phase index per symbol period, with a load strobe and an underrun flag.
module psk8_symbol_mapper #(
    parameter int unsigned SYM_CYCLES = 8,
    parameter int unsigned GRAY_EN    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic [2:0] select,
    output logic       sym_strobe,
    output logic       underrun
);

    localparam int unsigned TMR_W = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SYM_W = 3;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SYM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       shreg_q, shreg_d;
    logic [SYM_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [SYM_W-1:0] select_q, select_d;
    logic             sym_strobe_q, sym_strobe_d;
    logic             underrun_q, underrun_d;

    logic accept_c;
    logic boundary_c;

    function automatic logic [SYM_W-1:0] map_sym(input logic [SYM_W-1:0] s);
        if (GRAY_EN != 0) begin
            return {s[2], s[2] ^ s[1], s[2] ^ s[1] ^ s[0]};
        end
        return s;
    endfunction

    // Third bit is refused while a symbol is still pending, so completion and consumption never collide.
    assign bit_ready  = !(pend_valid_q && (cnt_q == CNT_LAST));
    assign accept_c   = bit_valid && bit_ready;
    assign boundary_c = enable && (tmr_q == '0);

    always_comb begin
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        tmr_d        = tmr_q;
        select_d     = select_q;
        sym_strobe_d = 1'b0;
        underrun_d   = 1'b0;

        if (!enable) begin
            tmr_d = '0;
        end else if (boundary_c) begin
            tmr_d = TMR_RELOAD;
        end else begin
            tmr_d = tmr_q - TMR_W'(1);
        end

        if (boundary_c) begin
            if (pend_valid_q) begin
                select_d     = map_sym(pend_q);
                pend_valid_d = 1'b0;
                sym_strobe_d = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end

        if (accept_c) begin
            if (cnt_q == CNT_LAST) begin
                pend_d       = {shreg_q, bit_in};
                pend_valid_d = 1'b1;
                cnt_d        = '0;
            end else begin
                shreg_d = {shreg_q[0], bit_in};
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tmr_q        <= '0;
            select_q     <= '0;
            sym_strobe_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tmr_q        <= tmr_d;
            select_q     <= select_d;
            sym_strobe_q <= sym_strobe_d;
            underrun_q   <= underrun_d;
        end
    end

    assign select     = select_q;
    assign sym_strobe = sym_strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_psk8_symbol_mapper.sv
// Self-checking bench for psk8_symbol_mapper: a Gray-mapped instance (4-cycle period) and a
// raw instance (8-cycle period), with a queue scoreboard plus directed timing sequences.
module tb_psk8_symbol_mapper;

    localparam int unsigned SYM_A = 4;
    localparam int unsigned SYM_B = 8;

    typedef struct {
        logic [2:0] sym;
        logic [2:0] exp_gray;
        logic [2:0] exp_raw;
    } vec_t;

    logic       clk, rst_n, enable;
    logic       bi_a, bv_a, br_a, stb_a, ur_a;
    logic       bi_b, bv_b, br_b, stb_b, ur_b;
    logic [2:0] sel_a, sel_b;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [2:0] q_a[$];
    logic [2:0] q_b[$];
    logic [2:0] sel_at_stb_a[$];
    int         stb_cyc_a[$];
    int         ur_at_stb_a[$];
    int         stb_cnt_a = 0, ur_cnt_a = 0, stb_cnt_b = 0, ur_cnt_b = 0;
    logic [2:0] asm_a = '0, asm_b = '0, exp_a, exp_b;
    int         nb_a = 0, nb_b = 0;

    vec_t vecs [8];

    psk8_symbol_mapper #(.SYM_CYCLES(SYM_A), .GRAY_EN(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bi_a), .bit_valid(bv_a),
        .bit_ready(br_a), .select(sel_a), .sym_strobe(stb_a), .underrun(ur_a));

    psk8_symbol_mapper #(.SYM_CYCLES(SYM_B), .GRAY_EN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bi_b), .bit_valid(bv_b),
        .bit_ready(br_b), .select(sel_b), .sym_strobe(stb_b), .underrun(ur_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference phase table written out literally, independent of the XOR form.
    function automatic logic [2:0] exp_map(input logic [2:0] s, input bit gray);
        if (!gray) return s;
        case (s)
            3'b000:  return 3'd0;
            3'b001:  return 3'd1;
            3'b011:  return 3'd2;
            3'b010:  return 3'd3;
            3'b110:  return 3'd4;
            3'b111:  return 3'd5;
            3'b101:  return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc_n);
    endtask

    // Scoreboards sample mid-cycle: outputs of the last edge, and handshakes for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete();
            nb_a = 0;
            asm_a = '0;
        end else begin
            if (stb_a) begin
                stb_cnt_a++;
                stb_cyc_a.push_back(cyc_n);
                ur_at_stb_a.push_back(ur_cnt_a);
                sel_at_stb_a.push_back(sel_a);
                if (q_a.size() == 0) begin
                    timeout("a_strobe_without_symbol");
                end else begin
                    exp_a = q_a.pop_front();
                    chk("a_scoreboard_select", int'(sel_a), int'(exp_a));
                end
            end
            if (ur_a) ur_cnt_a++;
            if (stb_a || ur_a) chk("a_pulse_exclusive", int'(stb_a & ur_a), 0);
            if (bv_a && br_a) begin
                asm_a = {asm_a[1:0], bi_a};
                nb_a++;
                if (nb_a == 3) begin
                    q_a.push_back(exp_map(asm_a, 1'b1));
                    nb_a = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q_b.delete();
            nb_b = 0;
            asm_b = '0;
        end else begin
            if (stb_b) begin
                stb_cnt_b++;
                if (q_b.size() == 0) begin
                    timeout("b_strobe_without_symbol");
                end else begin
                    exp_b = q_b.pop_front();
                    chk("b_scoreboard_select", int'(sel_b), int'(exp_b));
                end
            end
            if (ur_b) ur_cnt_b++;
            if (stb_b || ur_b) chk("b_pulse_exclusive", int'(stb_b & ur_b), 0);
            if (bv_b && br_b) begin
                asm_b = {asm_b[1:0], bi_b};
                nb_b++;
                if (nb_b == 3) begin
                    q_b.push_back(exp_map(asm_b, 1'b0));
                    nb_b = 0;
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit which, input logic b);
        int n = 0;
        if (!which) begin
            bv_a = 1'b1; bi_a = b;
            while (!br_a && n < 100) begin cyc(); n++; end
        end else begin
            bv_b = 1'b1; bi_b = b;
            while (!br_b && n < 100) begin cyc(); n++; end
        end
        if (n >= 100) timeout("send_bit");
        cyc();
        if (!which) bv_a = 1'b0; else bv_b = 1'b0;
    endtask

    task automatic send_sym(input bit which, input logic [2:0] s);
        send(which, s[2]);
        send(which, s[1]);
        send(which, s[0]);
    endtask

    task automatic wait_stb(input bit which, input int budget);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(which ? stb_b : stb_a) && n < budget);
        if (!(which ? stb_b : stb_a)) timeout("wait_strobe");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, u, ns, n, idx;
        logic [11:0] bp_bits;

        vecs[0] = '{3'b000, 3'd0, 3'b000};
        vecs[1] = '{3'b001, 3'd1, 3'b001};
        vecs[2] = '{3'b011, 3'd2, 3'b011};
        vecs[3] = '{3'b010, 3'd3, 3'b010};
        vecs[4] = '{3'b110, 3'd4, 3'b110};
        vecs[5] = '{3'b111, 3'd5, 3'b111};
        vecs[6] = '{3'b101, 3'd6, 3'b101};
        vecs[7] = '{3'b100, 3'd7, 3'b100};

        rst_n = 1'b0; enable = 1'b0;
        bi_a = 1'b0; bv_a = 1'b0; bi_b = 1'b0; bv_b = 1'b0;

        #2;
        chk("reset_select_a", int'(sel_a), 0);
        chk("reset_strobe_a", int'(stb_a), 0);
        chk("reset_underrun_a", int'(ur_a), 0);
        chk("reset_ready_a", int'(br_a), 1);
        chk("reset_ready_b", int'(br_b), 1);

        // First enabled edge after release is an empty boundary.
        cyc(2);
        rst_n = 1'b1; enable = 1'b1;
        cyc();
        chk("first_boundary_underrun_a", int'(ur_a), 1);
        chk("first_boundary_underrun_b", int'(ur_b), 1);
        chk("first_boundary_no_strobe_a", int'(stb_a), 0);
        cyc();
        chk("underrun_one_cycle_a", int'(ur_a), 0);

        // Back-to-back 011,100 -> 2 then 7, one period apart, no underrun between loads.
        s0 = stb_cnt_a;
        send_sym(1'b0, 3'b011);
        send_sym(1'b0, 3'b100);
        n = 0;
        while (stb_cnt_a < s0 + 2 && n < 40) begin cyc(); n++; end
        if (stb_cnt_a < s0 + 2) timeout("sequence_strobes");
        else begin
            chk("seq_first_select", int'(sel_at_stb_a[s0]), 2);
            chk("seq_second_select", int'(sel_at_stb_a[s0+1]), 7);
            chk("seq_strobe_spacing", stb_cyc_a[s0+1] - stb_cyc_a[s0], int'(SYM_A));
            chk("seq_no_underrun_between", ur_at_stb_a[s0+1], ur_at_stb_a[s0]);
        end

        // Mapping sweep on both instances.
        for (int i = 0; i < 8; i++) begin
            send_sym(1'b0, vecs[i].sym);
            wait_stb(1'b0, 12);
            chk("sweep_gray_select", int'(sel_a), int'(vecs[i].exp_gray));
            send_sym(1'b1, vecs[i].sym);
            wait_stb(1'b1, 20);
            chk("sweep_raw_select", int'(sel_b), int'(vecs[i].exp_raw));
        end

        // Backpressure on the 8-cycle instance, starting right after an empty boundary.
        n = 0;
        do begin cyc(); n++; end while (!ur_b && n < 20);
        if (!ur_b) timeout("bp_align");
        s0 = stb_cnt_b;
        bp_bits = 12'b101_011_110_001;
        idx = 0;
        for (int k = 0; k < 40 && idx < 12; k++) begin
            bv_b = 1'b1;
            bi_b = bp_bits[11-idx];
            if (k == 5) begin
                chk("bp_bits_before_stall", idx, 5);
                chk("bp_ready_low", int'(br_b), 0);
            end
            if (k == 7) chk("bp_ready_still_low", int'(br_b), 0);
            if (k == 8) chk("bp_ready_after_load", int'(br_b), 1);
            if (br_b) idx++;
            cyc();
        end
        bv_b = 1'b0;
        chk("bp_all_bits_taken", idx, 12);
        n = 0;
        while (stb_cnt_b < s0 + 4 && n < 60) begin cyc(); n++; end
        if (stb_cnt_b < s0 + 4) timeout("bp_drain");
        chk("bp_last_select", int'(sel_b), 3'b001);
        chk("bp_queue_empty", q_b.size(), 0);

        // One symbol then starvation: underrun every period, select holds.
        send_sym(1'b0, 3'b110);
        wait_stb(1'b0, 12);
        chk("ur_loaded_select", int'(sel_a), 4);
        u = 0; ns = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (ur_a) u++;
            if (stb_a) ns++;
            if (k == 3) chk("ur_not_early", int'(ur_a), 0);
            if (k == 4) chk("ur_at_period", int'(ur_a), 1);
        end
        chk("ur_count", u, 3);
        chk("ur_no_strobe", ns, 0);
        chk("ur_select_hold", int'(sel_a), 4);

        // Enable gating with a symbol pending.
        enable = 1'b0;
        send_sym(1'b0, 3'b011);
        ns = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (stb_a || ur_a) ns++;
        end
        chk("gate_no_pulses", ns, 0);
        chk("gate_select_hold", int'(sel_a), 4);
        enable = 1'b1;
        cyc();
        chk("gate_first_edge_strobe", int'(stb_a), 1);
        chk("gate_first_edge_select", int'(sel_a), 2);

        // Asynchronous reset with a pending symbol and two partial bits.
        enable = 1'b0;
        send_sym(1'b0, 3'b101);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        chk("rst_pre_ready_low", int'(br_a), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_select", int'(sel_a), 0);
        chk("rst_async_ready", int'(br_a), 1);
        chk("rst_async_strobe", int'(stb_a), 0);
        cyc();
        rst_n = 1'b1; enable = 1'b1;
        cyc();
        chk("rst_release_underrun", int'(ur_a), 1);
        chk("rst_release_no_strobe", int'(stb_a), 0);
        s0 = stb_cnt_a;
        cyc(10);
        chk("rst_symbol_discarded", stb_cnt_a - s0, 0);
        chk("rst_select_stays_zero", int'(sel_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/psk8_symbol_mapper.md
# psk8_symbol_mapper

Upstream stage of the 8-PSK phase multiplexer. Accepts a serial data bitstream over a valid/ready handshake and groups it into 3-bit symbols, MSB first. Each symbol is Gray-mapped to a phase index, buffered, and presented as the multiplexer's 3-bit `select` once per symbol period. It also asserts a one-cycle strobe per symbol and flags underrun when no symbol is ready at a boundary.

## Interface
Parameters:
- `SYM_CYCLES`, 8, clock cycles per symbol period; legal range 1..256.
- `GRAY_EN`, 1, 1 = Gray-decode symbol bits to phase index; 0 = pass bits straight through.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  symbol-period timer run; 0 freezes output updates.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` is valid.
- `bit_ready`  out  1  block accepts a bit this cycle.
- `select`  out  3  phase index driving the multiplexer select.
- `sym_strobe`  out  1  one-cycle pulse when `select` loads a new symbol.
- `underrun`  out  1  one-cycle pulse when a boundary finds no pending symbol.

## Operation
- **Assembler:**
  - 2-bit counter `cnt` (0..2) and 2-bit shift register.
  - A bit is accepted on an edge where `bit_valid && bit_ready`.
  - When `cnt` is 0 or 1, the accepted bit is shifted in and `cnt` increments.
  - When `cnt` is 2, the accepted bit completes symbol `{b_first, b_second, b_third}`. The symbol is written to the pending register, `pend_valid` is set to 1, and `cnt` wraps to 0.
- **Ready:** `bit_ready = !(pend_valid && cnt==2)`, decoded from registers only. The block never accepts a third bit while the pending register is occupied, including on the cycle the pending symbol is being consumed.
- **Mapping** (`GRAY_EN`=1): idx = {s2, s2^s1, s2^s1^s0}.
  - 000→0, 001→1, 011→2, 010→3, 110→4, 111→5, 101→6, 100→7.
  - Adjacent phases differ by one bit.
- **Symbol timer:** down-counter `tmr`.
  - When `enable`=0: `tmr` is held at 0; no loads, strobes or underruns occur.
  - Boundary edge: `enable`=1 and `tmr`=0. At a boundary, `tmr` reloads to `SYM_CYCLES`-1; otherwise it decrements while `enable`=1.
- **At a boundary edge:**
  - If `pend_valid`: `select` <= map(pending), `pend_valid` <= 0, `sym_strobe` <= 1.
  - Else: `select` holds its previous value, `underrun` <= 1.
- **Pulse width:** `sym_strobe` and `underrun` are 0 on every non-boundary edge, so each pulse is exactly one cycle. They are never both high.
- **Simultaneous completion:** If a symbol completes on the same edge the pending register is consumed, it cannot happen: ready blocks the third bit. After the consume edge, `bit_ready` returns to 1.
- **`SYM_CYCLES`=1:** every enabled cycle is a boundary.

## Timing
- **Reset values** (`rst_n`=0, asynchronous):
  - `select`=0, `sym_strobe`=0, `underrun`=0.
  - `cnt`=0, `pend_valid`=0, `tmr`=0, so `bit_ready`=1.
- **Reset mid-operation** discards partial bits and any pending symbol.
- **After reset release** with `enable`=1, the first edge is a boundary. That boundary raises `underrun` unless a symbol is already pending, which is impossible right after reset.
- **Latency:** third bit accepted on edge E, so `pend_valid` is visible after E. The earliest `select` update is edge E+1, visible in cycle E+1. The actual load waits for the next boundary.
- **Output rate:** with a continuous supply, `select` changes and `sym_strobe` pulses every `SYM_CYCLES` cycles.
- **Throughput:** sustained bit input up to 3 bits per `SYM_CYCLES`. Excess input is back-pressured through `bit_ready`, with no data loss.
- **Enable low mid-period:** `tmr` resets to 0. The next boundary is the first edge with `enable`=1.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `pend_valid`=1 → all outputs at reset values immediately (asynchronously); after release, the first enabled edge produces an `underrun` pulse.
- **Sequence:** `SYM_CYCLES`=4, `GRAY_EN`=1, bits 0,1,1 then 1,0,0 sent back-to-back → `select`=2 then, 4 cycles later, `select`=7; one `sym_strobe` per load; no `underrun` once started.
- **Mapping sweep:** send all 8 symbols.
  - `GRAY_EN`=1 → `select` follows 000→0 … 100→7 exactly.
  - `GRAY_EN`=0 → `select` equals the raw bits.
- **Backpressure:** `bit_valid` held at 1, `SYM_CYCLES`=8 → `bit_ready` drops after 5 bits are accepted (one symbol pending plus 2 bits) and rises the cycle after the boundary load; bit order is preserved.
- **Underrun:** supply one symbol, then stop → one `sym_strobe`, then one `underrun` pulse every `SYM_CYCLES` cycles; `select` holds its last value.
- **Enable gating:** `enable`=0 for 20 cycles with a symbol pending → no strobe and `select` unchanged; on `enable`=1, the load happens on that first edge.
